// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: EX/MEM entry, data-memory return and register-file write port bundle
interface mem_wb_stage_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             in_valid;
  logic [WIDTH-1:0] in_alu_result;
  logic [WIDTH-1:0] in_pc_plus8;
  logic [REGW-1:0]  in_dest;
  logic [1:0]       in_wb_sel;
  logic             in_reg_write;
  logic             in_mem_read;
  logic [1:0]       in_load_size;
  logic             in_load_unsigned;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_rvalid;
  logic             stall_out;
  logic [REGW-1:0]  write_reg;
  logic [WIDTH-1:0] write_data_reg;
  logic [1:0]       RegWrite;
  modport master (
    output in_valid, in_alu_result, in_pc_plus8, in_dest, in_wb_sel, in_reg_write,
           in_mem_read, in_load_size, in_load_unsigned, mem_rdata, mem_rvalid,
    input  stall_out, write_reg, write_data_reg, RegWrite
  );
  modport slave (
    input  in_valid, in_alu_result, in_pc_plus8, in_dest, in_wb_sel, in_reg_write,
           in_mem_read, in_load_size, in_load_unsigned, mem_rdata, mem_rvalid,
    output stall_out, write_reg, write_data_reg, RegWrite
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB stage; waits on load returns, extends load data, drives the register-file write port
module mem_wb_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic         clk,
  input  logic         rst,
  mem_wb_stage_if.slave bus
);
  localparam logic [1:0] RUN = 2'd0, WAIT_MEM = 2'd1, WB_LOAD = 2'd2;
  logic [1:0]       state, state_nx;
  logic             e_valid, e_rw, e_mr, e_uns, accept, do_write;
  logic [WIDTH-1:0] e_alu, e_pc8, load_val, ext, wdata, last_data;
  logic [REGW-1:0]  e_dest, last_reg;
  logic [1:0]       e_sel, e_size;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  assign bus.stall_out = state == WAIT_MEM;
  assign accept = bus.in_valid && !bus.stall_out;
  assign do_write = e_valid && state != WAIT_MEM && e_rw && e_dest != '0;
  // big-endian lanes: byte k sits at bit 8*(3-k), and 3-k is just ~k for a 2-bit k
  assign rbyte = bus.mem_rdata[{~e_alu[1:0], 3'b000} +: 8];
  assign rhalf = bus.mem_rdata[{~e_alu[1], 4'b0000} +: 16];
  always_comb begin
    ext = e_size == 2'b00 ? {{(WIDTH-8){~e_uns & rbyte[7]}}, rbyte}
        : e_size == 2'b01 ? {{(WIDTH-16){~e_uns & rhalf[15]}}, rhalf}
        : bus.mem_rdata;
    wdata = e_sel == 2'b01 ? load_val : e_sel == 2'b10 ? e_pc8 : e_alu;
    state_nx = bus.stall_out ? (bus.mem_rvalid ? WB_LOAD : WAIT_MEM)
             : (accept && bus.in_mem_read ? WAIT_MEM : RUN);
  end
  // the write port shows the live entry only while writing; otherwise the last write is held
  assign bus.write_reg = do_write ? e_dest : last_reg;
  assign bus.write_data_reg = do_write ? wdata : last_data;
  assign bus.RegWrite = {1'b0, do_write};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      e_valid <= 1'b0;
      e_alu <= '0;
      e_pc8 <= '0;
      e_dest <= '0;
      e_sel <= '0;
      e_rw <= 1'b0;
      e_mr <= 1'b0;
      e_size <= '0;
      e_uns <= 1'b0;
      load_val <= '0;
      last_reg <= '0;
      last_data <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        e_valid <= 1'b1;
        e_alu <= bus.in_alu_result;
        e_pc8 <= bus.in_pc_plus8;
        e_dest <= bus.in_dest;
        e_sel <= bus.in_wb_sel;
        e_rw <= bus.in_reg_write;
        e_mr <= bus.in_mem_read;
        e_size <= bus.in_load_size;
        e_uns <= bus.in_load_unsigned;
      end else if (!bus.stall_out) e_valid <= 1'b0;
      if (bus.stall_out && bus.mem_rvalid) load_val <= ext;
      if (do_write) begin
        last_reg <= e_dest;
        last_data <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  mem_wb_stage_if #(.WIDTH(32), .REGW(5)) bus ();
  mem_wb_stage #(.WIDTH(32), .REGW(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic [31:0] alu, input logic [31:0] pc8, input logic [4:0] dest,
                     input logic [1:0] sel, input logic rw, input logic mr,
                     input logic [1:0] size, input logic uns);
    bus.in_valid = 1'b1;
    bus.in_alu_result = alu;
    bus.in_pc_plus8 = pc8;
    bus.in_dest = dest;
    bus.in_wb_sel = sel;
    bus.in_reg_write = rw;
    bus.in_mem_read = mr;
    bus.in_load_size = size;
    bus.in_load_unsigned = uns;
  endtask
  task automatic port(input string tag, input logic [1:0] rw, input logic [4:0] r, input logic [31:0] d);
    chk({tag, "_rw"}, {30'd0, bus.RegWrite}, {30'd0, rw});
    chk({tag, "_reg"}, {27'd0, bus.write_reg}, {27'd0, r});
    chk({tag, "_data"}, bus.write_data_reg, d);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    drv(32'd0, 32'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    bus.in_valid = 1'b0;
    bus.mem_rdata = 32'd0;
    bus.mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, bus.stall_out}, 32'd0);
    port("rst", 2'b00, 5'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    drv(32'h5, 32'h0, 5'd8, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    port("alu1", 2'b01, 5'd8, 32'h5);
    drv(32'hFFFFFFFF, 32'h0, 5'd9, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    port("alu2", 2'b01, 5'd9, 32'hFFFFFFFF);
    bus.in_valid = 1'b0;
    @(negedge clk);
    port("alu_hold", 2'b00, 5'd9, 32'hFFFFFFFF);
    drv(32'h1001, 32'h0, 5'd10, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("lb_stall%0d", i), {31'd0, bus.stall_out}, 32'd1);
      chk($sformatf("lb_nowr%0d", i), {30'd0, bus.RegWrite}, 32'd0);
    end
    bus.mem_rdata = 32'h12F45678;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'h0BADF00D;
    chk("lb_stall_end", {31'd0, bus.stall_out}, 32'd0);
    port("lb", 2'b01, 5'd10, 32'hFFFFFFF4);
    @(negedge clk);
    chk("lb_once", {30'd0, bus.RegWrite}, 32'd0);
    drv(32'h2002, 32'h0, 5'd11, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1);
    bus.mem_rdata = 32'hAAAA8001;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("lhu_stall", {31'd0, bus.stall_out}, 32'd1);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("lhu_stall_end", {31'd0, bus.stall_out}, 32'd0);
    port("lhu", 2'b01, 5'd11, 32'h00008001);
    @(negedge clk);
    drv(32'h1234, 32'h00400010, 5'd31, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    port("jal", 2'b01, 5'd31, 32'h00400010);
    @(negedge clk);
    chk("jal_once", {30'd0, bus.RegWrite}, 32'd0);
    drv(32'h7, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    port("zero", 2'b00, 5'd31, 32'h00400010);
    drv(32'h100, 32'h0, 5'd12, 2'b01, 1'b1, 1'b1, 2'b10, 1'b0);
    @(negedge clk);
    drv(32'h77, 32'h0, 5'd13, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("hold_stall0", {31'd0, bus.stall_out}, 32'd1);
    @(negedge clk);
    chk("hold_stall1", {31'd0, bus.stall_out}, 32'd1);
    bus.mem_rdata = 32'hDEADBEEF;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("lw_stall_end", {31'd0, bus.stall_out}, 32'd0);
    port("lw", 2'b01, 5'd12, 32'hDEADBEEF);
    @(negedge clk);
    bus.in_valid = 1'b0;
    port("held_alu", 2'b01, 5'd13, 32'h77);
    @(negedge clk);
    chk("held_once", {30'd0, bus.RegWrite}, 32'd0);
    drv(32'h3, 32'h0, 5'd14, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_stall", {31'd0, bus.stall_out}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_stall", {31'd0, bus.stall_out}, 32'd0);
    port("arst", 2'b00, 5'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_rdata = 32'h11223344;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("post_stall", {31'd0, bus.stall_out}, 32'd0);
    port("post", 2'b00, 5'd0, 32'd0);
    @(negedge clk);
    chk("post2_stall", {31'd0, bus.stall_out}, 32'd0);
    chk("post2_rw", {30'd0, bus.RegWrite}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
